// File: rtl/branch_target_buffer_pkg.sv
// Shared branch-prediction types: 2-bit direction counter encoding, its
// next-state function, and the BTB entry layout. Also used by execute-stage
// mispredict logic so both ends agree on the counter encoding.
// Pure declarations; no latency, no backpressure.
package branch_target_buffer_pkg;

    // Width of the tag/target fields held in an entry. Tags are stored
    // zero-extended into this width, so any XLEN up to this value fits.
    localparam int BTB_XLEN = 32;

    typedef logic [1:0] ctr_t;

    localparam ctr_t NTS = 2'b00;   // not taken, strong
    localparam ctr_t NTW = 2'b01;   // not taken, weak
    localparam ctr_t TW  = 2'b10;   // taken, weak
    localparam ctr_t TS  = 2'b11;   // taken, strong

    typedef struct packed {
        logic                valid;
        logic [BTB_XLEN-1:0] tag;
        logic [BTB_XLEN-1:0] target;
        ctr_t                ctr;
    } btb_entry_t;

    // Counter advance on a resolved branch. Note the asymmetry: a weakly
    // not-taken branch that turns out taken jumps straight to strong taken,
    // and any not-taken outcome below TS collapses to strong not-taken.
    function automatic ctr_t next_ctr(ctr_t cur, logic taken);
        ctr_t nxt;
        nxt = cur;
        if (taken) begin
            case (cur)
                NTS:     nxt = NTW;
                default: nxt = TS;
            endcase
        end else begin
            case (cur)
                TS:      nxt = TW;
                default: nxt = NTS;
            endcase
        end
        return nxt;
    endfunction

endpackage

// File: rtl/btb_array.sv
// BTB storage: ENTRIES x btb_entry_t, two combinational read ports (fetch
// lookup and execute update), one synchronous write port, bulk valid clear.
// Reads 0 cycles; writes visible next cycle; always accepts, no backpressure.
// Ports: clk, rst_n (sync, active-low), clr_valid, lk_idx/lk_entry,
//        up_idx/up_entry, wr_en/wr_idx/wr_entry.
module btb_array
    import branch_target_buffer_pkg::*;
#(
    parameter int ENTRIES = 16,
    localparam int IDX_W  = $clog2(ENTRIES)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_valid,
    input  logic [IDX_W-1:0] lk_idx,
    output btb_entry_t       lk_entry,
    input  logic [IDX_W-1:0] up_idx,
    output btb_entry_t       up_entry,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  btb_entry_t       wr_entry
);

    btb_entry_t mem [ENTRIES];

    assign lk_entry = mem[lk_idx];
    assign up_entry = mem[up_idx];

    // Reset beats clear beats write: a write arriving with a clear is dropped.
    // Clear touches only valid bits; target and counter survive a flush.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                mem[i] <= '0;
            end
        end else if (clr_valid) begin
            for (int i = 0; i < ENTRIES; i++) begin
                mem[i].valid <= 1'b0;
            end
        end else if (wr_en) begin
            mem[wr_idx] <= wr_entry;
        end
    end

endmodule

// File: rtl/branch_target_buffer.sv
// Direct-mapped branch target buffer with 2-bit direction counters; predicts
// the next fetch PC and learns from execute-stage resolved branches.
// Lookup 0 cycles; updates visible next cycle; update port never stalls.
// Ports: clk, rst_n (sync, active-low), flush, if_pc -> pred_hit, pred_taken,
//        pred_next_pc; upd_valid, upd_pc, upd_taken, upd_target.
// Option: BTB_BYPASS_EN forwards a same-cycle update at the same PC to the
//        lookup outputs.
module branch_target_buffer
    import branch_target_buffer_pkg::*;
#(
    parameter int ENTRIES = 16,
    parameter int XLEN    = BTB_XLEN,
    localparam int IDX_W  = $clog2(ENTRIES)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic [XLEN-1:0] if_pc,
    output logic            pred_hit,
    output logic            pred_taken,
    output logic [XLEN-1:0] pred_next_pc,
    input  logic            upd_valid,
    input  logic [XLEN-1:0] upd_pc,
    input  logic            upd_taken,
    input  logic [XLEN-1:0] upd_target
);

    logic [IDX_W-1:0]    lk_idx;
    logic [IDX_W-1:0]    up_idx;
    logic [BTB_XLEN-1:0] lk_tag;
    logic [BTB_XLEN-1:0] up_tag;
    btb_entry_t          lk_entry;
    btb_entry_t          up_entry;
    btb_entry_t          wr_entry;
    btb_entry_t          sel_entry;
    logic                wr_en;
    logic                upd_hit;

    // Instruction-aligned PCs: bits [1:0] never take part in index or tag.
    assign lk_idx = if_pc[IDX_W+1:2];
    assign up_idx = upd_pc[IDX_W+1:2];
    assign lk_tag = BTB_XLEN'(if_pc[XLEN-1:IDX_W+2]);
    assign up_tag = BTB_XLEN'(upd_pc[XLEN-1:IDX_W+2]);

    logic unused_pc_lsbs;
    assign unused_pc_lsbs = ^{if_pc[1:0], upd_pc[1:0]};

    btb_array #(
        .ENTRIES (ENTRIES)
    ) u_array (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr_valid (flush),
        .lk_idx    (lk_idx),
        .lk_entry  (lk_entry),
        .up_idx    (up_idx),
        .up_entry  (up_entry),
        .wr_en     (wr_en),
        .wr_idx    (up_idx),
        .wr_entry  (wr_entry)
    );

    assign upd_hit = up_entry.valid && (up_entry.tag == up_tag);

    // Hit: advance counter, refresh target only on taken.
    // Miss + taken: allocate over whatever lives at this index, start at TW.
    // Miss + not taken: leave the table alone.
    always_comb begin
        wr_en    = 1'b0;
        wr_entry = up_entry;
        if (upd_valid) begin
            if (upd_hit) begin
                wr_en        = 1'b1;
                wr_entry.ctr = next_ctr(up_entry.ctr, upd_taken);
                if (upd_taken) begin
                    wr_entry.target = BTB_XLEN'(upd_target);
                end
            end else if (upd_taken) begin
                wr_en           = 1'b1;
                wr_entry.valid  = 1'b1;
                wr_entry.tag    = up_tag;
                wr_entry.target = BTB_XLEN'(upd_target);
                wr_entry.ctr    = TW;
            end
        end
    end

    always_comb begin
        sel_entry = lk_entry;
`ifdef BTB_BYPASS_EN
        // Same word address means same index and tag, so the entry being
        // written is exactly the one being looked up. Flush and reset both
        // discard the write, so they must also kill the forward.
        if (rst_n && !flush && wr_en &&
            (upd_pc[XLEN-1:2] == if_pc[XLEN-1:2])) begin
            sel_entry = wr_entry;
        end
`endif
    end

    assign pred_hit     = sel_entry.valid && (sel_entry.tag == lk_tag);
    assign pred_taken   = pred_hit && sel_entry.ctr[1];
    assign pred_next_pc = pred_taken ? sel_entry.target[XLEN-1:0]
                                     : if_pc + XLEN'(4);

endmodule

// File: tb/tb_branch_target_buffer.sv
module tb_branch_target_buffer;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic [31:0] if_pc;
    logic        pred_hit;
    logic        pred_taken;
    logic [31:0] pred_next_pc;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic [31:0] upd_target;

    int tests = 0;
    int fails = 0;

    branch_target_buffer #(.ENTRIES(16), .XLEN(32)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush        (flush),
        .if_pc        (if_pc),
        .pred_hit     (pred_hit),
        .pred_taken   (pred_taken),
        .pred_next_pc (pred_next_pc),
        .upd_valid    (upd_valid),
        .upd_pc       (upd_pc),
        .upd_taken    (upd_taken),
        .upd_target   (upd_target)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model (16 entries: idx=pc[5:2], tag=pc>>6)
    bit          m_valid [16];
    logic [31:0] m_tag   [16];
    logic [31:0] m_tgt   [16];
    int          m_ctr   [16];   // 0=NTS 1=NTW 2=TW 3=TS; taken iff >= 2

    function automatic void model_post(input logic [31:0] pc, input bit tk,
                                       input logic [31:0] t, output bit wr,
                                       output bit nv, output logic [31:0] ntag,
                                       output logic [31:0] ntgt, output int nctr);
        int          i;
        logic [31:0] tg;
        bit          hit;
        i    = int'(pc[5:2]);
        tg   = pc >> 6;
        hit  = m_valid[i] && (m_tag[i] == tg);
        wr   = 1'b0;
        nv   = m_valid[i];
        ntag = m_tag[i];
        ntgt = m_tgt[i];
        nctr = m_ctr[i];
        if (hit) begin
            wr   = 1'b1;
            nctr = tk ? ((m_ctr[i] == 0) ? 1 : 3) : ((m_ctr[i] == 3) ? 2 : 0);
            if (tk) ntgt = t;
        end else if (tk) begin
            wr   = 1'b1;
            nv   = 1'b1;
            ntag = tg;
            ntgt = t;
            nctr = 2;
        end
    endfunction

    always @(posedge clk) begin
        bit          wr;
        bit          nv;
        logic [31:0] ntag;
        logic [31:0] ntgt;
        int          nctr;
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) begin
                m_valid[i] = 1'b0; m_ctr[i] = 0; m_tgt[i] = 32'h0; m_tag[i] = 32'h0;
            end
        end else if (flush) begin
            for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
        end else if (upd_valid) begin
            model_post(upd_pc, upd_taken, upd_target, wr, nv, ntag, ntgt, nctr);
            if (wr) begin
                m_valid[upd_pc[5:2]] = nv;
                m_tag[upd_pc[5:2]]   = ntag;
                m_tgt[upd_pc[5:2]]   = ntgt;
                m_ctr[upd_pc[5:2]]   = nctr;
            end
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    // Continuous compare against the model whenever out of reset.
    always @(negedge clk) begin
        int          i;
        bit          hit;
        bit          tk;
        logic [31:0] nxt;
        bit          wr;
        bit          nv;
        logic [31:0] ntag;
        logic [31:0] ntgt;
        int          nctr;
        if (rst_n === 1'b1) begin
            i   = int'(if_pc[5:2]);
            hit = m_valid[i] && (m_tag[i] == (if_pc >> 6));
            tk  = hit && (m_ctr[i] >= 2);
            nxt = tk ? m_tgt[i] : if_pc + 32'd4;
`ifdef BTB_BYPASS_EN
            if (upd_valid && !flush && (upd_pc[31:2] == if_pc[31:2])) begin
                model_post(upd_pc, upd_taken, upd_target, wr, nv, ntag, ntgt, nctr);
                if (wr) begin
                    hit = nv && (ntag == (if_pc >> 6));
                    tk  = hit && (nctr >= 2);
                    nxt = tk ? ntgt : if_pc + 32'd4;
                end
            end
`endif
            check("model_hit",   {31'd0, pred_hit},   {31'd0, hit});
            check("model_taken", {31'd0, pred_taken}, {31'd0, tk});
            check("model_next",  pred_next_pc, nxt);
        end
    end

    // ---------------- directed stimulus with literal expectations
    task automatic step(input string nm, input logic [31:0] lk,
                        input bit uv, input logic [31:0] upc, input bit utk,
                        input logic [31:0] utgt, input bit fl,
                        input bit eh, input bit et, input logic [31:0] en);
        if_pc      = lk;
        upd_valid  = uv;
        upd_pc     = upc;
        upd_taken  = utk;
        upd_target = utgt;
        flush      = fl;
        @(negedge clk);
        check({nm, "_hit"},   {31'd0, pred_hit},   {31'd0, eh});
        check({nm, "_taken"}, {31'd0, pred_taken}, {31'd0, et});
        check({nm, "_next"},  pred_next_pc, en);
        @(posedge clk);
        #1;
    endtask

    task automatic look(input string nm, input logic [31:0] lk,
                        input bit eh, input bit et, input logic [31:0] en);
        step(nm, lk, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, eh, et, en);
    endtask

    initial begin
        // Reset with a live update that must be discarded.
        rst_n = 1'b0; flush = 1'b0; if_pc = 32'h100;
        upd_valid = 1'b1; upd_pc = 32'h100; upd_taken = 1'b1; upd_target = 32'h80;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1; upd_valid = 1'b0;

        look("reset", 32'h100, 0, 0, 32'h104);

        // Same-cycle allocate and lookup of the same PC.
`ifdef BTB_BYPASS_EN
        step("same_cyc", 32'h100, 1, 32'h100, 1, 32'h80, 0, 1, 1, 32'h80);
`else
        step("same_cyc", 32'h100, 1, 32'h100, 1, 32'h80, 0, 0, 0, 32'h104);
`endif
        look("alloc_tw", 32'h100, 1, 1, 32'h80);
        step("tk_to_ts", 32'h100, 1, 32'h100, 1, 32'h80, 0, 1, 1, 32'h80);
        step("ts_nt",    32'h100, 1, 32'h100, 0, 32'h0,  0, 1, 1, 32'h80);
        look("tw",       32'h100, 1, 1, 32'h80);
        step("tw_nt",    32'h104, 1, 32'h100, 0, 32'h0,  0, 0, 0, 32'h108);
        look("nts",      32'h100, 1, 0, 32'h104);
        step("nts_tk",   32'h104, 1, 32'h100, 1, 32'h80, 0, 0, 0, 32'h108);
        look("ntw",      32'h100, 1, 0, 32'h104);
        step("ntw_tk",   32'h104, 1, 32'h100, 1, 32'h90, 0, 0, 0, 32'h108);
        look("ntw_to_ts", 32'h100, 1, 1, 32'h90);
        step("ts_nt2",   32'h104, 1, 32'h100, 0, 32'h0,  0, 0, 0, 32'h108);
        look("ts_to_tw", 32'h100, 1, 1, 32'h90);

        // Aliasing allocation at index 0.
        step("alias",     32'h104, 1, 32'h140, 1, 32'h200, 0, 0, 0, 32'h108);
        look("alias_old", 32'h100, 0, 0, 32'h104);
        look("alias_new", 32'h140, 1, 1, 32'h200);

        // Not-taken miss changes nothing (0x300 also maps to index 0).
        step("nt_miss",   32'h104, 1, 32'h300, 0, 32'h0, 0, 0, 0, 32'h108);
        look("nt_miss_a", 32'h300, 0, 0, 32'h304);
        look("nt_miss_b", 32'h140, 1, 1, 32'h200);

        // Separate index.
        step("idx1",     32'h100, 1, 32'h104, 1, 32'h400, 0, 0, 0, 32'h104);
        look("idx1_chk", 32'h104, 1, 1, 32'h400);

        // Flush with a concurrent taken update.
        step("flush",  32'h180, 1, 32'h180, 1, 32'h10, 1, 0, 0, 32'h184);
        look("fl_180", 32'h180, 0, 0, 32'h184);
        look("fl_140", 32'h140, 0, 0, 32'h144);
        look("fl_104", 32'h104, 0, 0, 32'h108);

        // PC low bits ignored for index/tag.
        step("lowbits", 32'h104, 1, 32'h202, 1, 32'h44, 0, 0, 0, 32'h108);
        look("low_200", 32'h200, 1, 1, 32'h44);
        look("low_203", 32'h203, 1, 1, 32'h44);

        // Fall-through wraps.
        look("wrap", 32'hFFFF_FFFC, 0, 0, 32'h0);

        // Mid-operation reset discards concurrent update and clears table.
        rst_n = 1'b0; upd_valid = 1'b1; upd_pc = 32'h500; upd_taken = 1'b1; upd_target = 32'h20;
        @(posedge clk);
        #1;
        rst_n = 1'b1; upd_valid = 1'b0;
        look("rst_200", 32'h200, 0, 0, 32'h204);
        look("rst_500", 32'h500, 0, 0, 32'h504);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule
